// File: rtl/cpu_writeback.sv
// cpu_writeback: memory/writeback stage with 64x32 data RAM, UART tx request and commit record.
// Define CPU_WB_STALL_CNT_EN to add the stall_cnt port and counter.
module cpu_writeback #(
  parameter int DMEM_WORDS = 64,
  parameter int RF_AW = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [RF_AW-1:0]              ex_rd,
  input  logic [31:0]                   ex_pc,
  input  logic [31:0]                   ex_intr_pc,
  input  logic [31:0]                   ex_intr_vec,
  input  logic                          ex_intr_en,
  input  logic                          ex_ack,
  input  logic                          ex_w_rd,
  input  logic                          ex_mem_r_req,
  input  logic                          ex_mem_w_req,
  input  logic                          ex_tx_req,
  input  logic [31:0]                   ex_x_rd,
  input  logic [7:0]                    ex_tx_data,
  input  logic [$clog2(DMEM_WORDS)-1:0] ex_mem_addr,
`ifdef CPU_WB_STALL_CNT_EN
  output logic [31:0]                   stall_cnt,
`endif
  output logic                          rf_we,
  output logic [RF_AW-1:0]              rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic                          cm_valid,
  output logic [31:0]                   cm_pc,
  output logic [31:0]                   cm_intr_pc,
  output logic [31:0]                   cm_intr_vec,
  output logic                          cm_intr_en,
  output logic                          intr_ack
);
  typedef enum logic [1:0] {IDLE, LOAD, TX, COMMIT} state_t;
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [31:0]      pc, ipc, ivec, xrd;
    logic [7:0]       txd;
    logic             ien, ack, wrd;
  } hold_t;
  state_t state_q, state_d;
  hold_t hold_q, hold_d;
  logic ex_ready_q, ex_ready_d, rf_we_q, rf_we_d, cm_valid_q, cm_valid_d;
  logic intr_ack_q, intr_ack_d, tx_valid_q, tx_valid_d;
  logic acc, wr_req, tx_req;
  logic [31:0] mem [DMEM_WORDS];
  logic [31:0] ram_q;
  assign acc    = ex_valid && ex_ready_q;
  assign wr_req = !ex_mem_r_req && ex_mem_w_req;
  assign tx_req = !ex_mem_r_req && !ex_mem_w_req && ex_tx_req;
  always_comb begin
    hold_d = hold_q;
    if (acc)
      hold_d = '{rd: ex_rd, pc: ex_pc, ipc: ex_intr_pc, ivec: ex_intr_vec, xrd: ex_x_rd,
                 txd: ex_tx_data, ien: ex_intr_en, ack: ex_ack, wrd: ex_w_rd && !wr_req};
    if (state_q == LOAD) hold_d.xrd = ram_q;
    state_d = state_q == IDLE ? (!acc ? IDLE : ex_mem_r_req ? LOAD : tx_req ? TX : COMMIT) :
              state_q == LOAD ? COMMIT :
              state_q == TX   ? (tx_ready ? COMMIT : TX) : IDLE;
    ex_ready_d = state_d == IDLE;
    tx_valid_d = state_d == TX;
    cm_valid_d = state_d == COMMIT;
    rf_we_d    = cm_valid_d && hold_d.wrd && hold_d.rd != '0;
    intr_ack_d = cm_valid_d && hold_d.ack;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      ex_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      cm_valid_q <= 1'b0;
      rf_we_q    <= 1'b0;
      intr_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ex_ready_q <= ex_ready_d;
      tx_valid_q <= tx_valid_d;
      cm_valid_q <= cm_valid_d;
      rf_we_q    <= rf_we_d;
      intr_ack_q <= intr_ack_d;
    end
  end
  // Data RAM is not reset; write and read both happen on the accept edge.
  always_ff @(posedge clk) begin
    if (acc && wr_req) mem[ex_mem_addr] <= ex_x_rd;
    if (acc && ex_mem_r_req) ram_q <= mem[ex_mem_addr];
  end
`ifdef CPU_WB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = stall_q + 32'((ex_valid && !ex_ready_q) || (state_q == TX && !tx_ready));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else stall_q <= stall_d;
  assign stall_cnt = stall_q;
`endif
  assign ex_ready    = ex_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = hold_q.txd;
  assign cm_valid    = cm_valid_q;
  assign rf_we       = rf_we_q;
  assign intr_ack    = intr_ack_q;
  assign rf_waddr    = hold_q.rd;
  assign rf_wdata    = hold_q.xrd;
  assign cm_pc       = hold_q.pc;
  assign cm_intr_pc  = hold_q.ipc;
  assign cm_intr_vec = hold_q.ivec;
  assign cm_intr_en  = hold_q.ien;
endmodule

// File: tb/tb_cpu_writeback.sv
// tb_cpu_writeback: directed checks of the writeback stage (plain, store/load, tx, rd0, priority, irq, reset).
module tb_cpu_writeback;
  logic clk = 0, rst_n = 0;
  logic ex_valid, ex_ready, ex_intr_en, ex_ack, ex_w_rd, ex_mem_r_req, ex_mem_w_req, ex_tx_req;
  logic [3:0] ex_rd, rf_waddr;
  logic [31:0] ex_pc, ex_intr_pc, ex_intr_vec, ex_x_rd, rf_wdata, cm_pc, cm_intr_pc, cm_intr_vec;
  logic [7:0] ex_tx_data, tx_data;
  logic [5:0] ex_mem_addr;
  logic rf_we, tx_valid, tx_ready, cm_valid, cm_intr_en, intr_ack;
`ifdef CPU_WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int total = 0, passed = 0;

  cpu_writeback dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_intr_pc(ex_intr_pc), .ex_intr_vec(ex_intr_vec), .ex_intr_en(ex_intr_en),
    .ex_ack(ex_ack), .ex_w_rd(ex_w_rd), .ex_mem_r_req(ex_mem_r_req), .ex_mem_w_req(ex_mem_w_req),
    .ex_tx_req(ex_tx_req), .ex_x_rd(ex_x_rd), .ex_tx_data(ex_tx_data), .ex_mem_addr(ex_mem_addr),
`ifdef CPU_WB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_intr_pc(cm_intr_pc),
    .cm_intr_vec(cm_intr_vec), .cm_intr_en(cm_intr_en), .intr_ack(intr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    {ex_valid, ex_intr_en, ex_ack, ex_w_rd, ex_mem_r_req, ex_mem_w_req, ex_tx_req} = '0;
    {ex_rd, ex_pc, ex_intr_pc, ex_intr_vec, ex_x_rd, ex_tx_data, ex_mem_addr} = '0;
  endtask

  initial begin
    clr();
    tx_ready = 0;
    tick();
    tick();
    chk("rst_ready", 32'(ex_ready), 0);
    chk("rst_cm_valid", 32'(cm_valid), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_cm_pc", cm_pc, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
`ifdef CPU_WB_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    rst_n = 1;
    tick();
    chk("idle_ready", 32'(ex_ready), 1);
    // plain record
    ex_valid = 1; ex_w_rd = 1; ex_rd = 3; ex_x_rd = 32'h1234; ex_pc = 32'h10;
    tick();
    chk("plain_rf_we", 32'(rf_we), 1);
    chk("plain_waddr", 32'(rf_waddr), 3);
    chk("plain_wdata", rf_wdata, 32'h1234);
    chk("plain_cm_valid", 32'(cm_valid), 1);
    chk("plain_cm_pc", cm_pc, 32'h10);
    chk("plain_ready_lo", 32'(ex_ready), 0);
    clr();
    tick();
    chk("plain_ready_hi", 32'(ex_ready), 1);
    chk("plain_cm_pulse", 32'(cm_valid), 0);
    chk("plain_we_pulse", 32'(rf_we), 0);
    // store then load to address 63
    ex_valid = 1; ex_mem_w_req = 1; ex_x_rd = 32'hDEADBEEF; ex_mem_addr = 63; ex_w_rd = 1; ex_rd = 7;
    tick();
    chk("st_cm_valid", 32'(cm_valid), 1);
    chk("st_no_rf_we", 32'(rf_we), 0);
    chk("st_ready_lo", 32'(ex_ready), 0);
    clr();
    ex_valid = 1; ex_mem_r_req = 1; ex_mem_addr = 63; ex_rd = 5; ex_w_rd = 1; ex_x_rd = 32'h55;
    tick();
    chk("ld_wait_ready", 32'(ex_ready), 1);
    tick();
    chk("ld_load_ready", 32'(ex_ready), 0);
    chk("ld_load_cm", 32'(cm_valid), 0);
    clr();
    tick();
    chk("ld_cm_valid", 32'(cm_valid), 1);
    chk("ld_rf_we", 32'(rf_we), 1);
    chk("ld_waddr", 32'(rf_waddr), 5);
    chk("ld_wdata", rf_wdata, 32'hDEADBEEF);
    chk("ld_ready_lo2", 32'(ex_ready), 0);
    tick();
    chk("ld_ready_hi", 32'(ex_ready), 1);
    // tx with five cycles of backpressure
    ex_valid = 1; ex_tx_req = 1; ex_tx_data = 8'h41; ex_pc = 32'h20;
    tick();
    clr();
    for (int i = 0; i < 5; i++) begin
      chk("tx_valid_wait", 32'(tx_valid), 1);
      chk("tx_data_wait", 32'(tx_data), 32'h41);
      chk("tx_no_cm", 32'(cm_valid), 0);
      tick();
    end
    tx_ready = 1;
    chk("tx_valid_hs", 32'(tx_valid), 1);
    chk("tx_data_hs", 32'(tx_data), 32'h41);
    tick();
    tx_ready = 0;
    chk("tx_cm_valid", 32'(cm_valid), 1);
    chk("tx_cm_pc", cm_pc, 32'h20);
    chk("tx_valid_drop", 32'(tx_valid), 0);
`ifdef CPU_WB_STALL_CNT_EN
    chk("tx_stall_cnt", stall_cnt, 6);
`endif
    tick();
    // write to r0 suppressed
    ex_valid = 1; ex_w_rd = 1; ex_rd = 0; ex_x_rd = 32'h99;
    tick();
    chk("r0_cm_valid", 32'(cm_valid), 1);
    chk("r0_no_we", 32'(rf_we), 0);
    clr();
    tick();
    // store wins over tx
    ex_valid = 1; ex_mem_w_req = 1; ex_tx_req = 1; ex_mem_addr = 10; ex_x_rd = 32'hCAFEF00D;
    tick();
    chk("prio_cm_valid", 32'(cm_valid), 1);
    chk("prio_no_tx", 32'(tx_valid), 0);
    clr();
    tick();
    chk("prio_no_tx2", 32'(tx_valid), 0);
    ex_valid = 1; ex_mem_r_req = 1; ex_mem_addr = 10; ex_rd = 2; ex_w_rd = 1;
    tick();
    clr();
    tick();
    chk("prio_ld_wdata", rf_wdata, 32'hCAFEF00D);
    chk("prio_ld_waddr", 32'(rf_waddr), 2);
    tick();
    // interrupt acknowledge
    ex_valid = 1; ex_ack = 1; ex_intr_en = 1; ex_intr_vec = 32'h80; ex_intr_pc = 32'h44;
    tick();
    chk("irq_ack", 32'(intr_ack), 1);
    chk("irq_en", 32'(cm_intr_en), 1);
    chk("irq_vec", cm_intr_vec, 32'h80);
    chk("irq_pc", cm_intr_pc, 32'h44);
    clr();
    tick();
    chk("irq_ack_pulse", 32'(intr_ack), 0);
    chk("irq_cm_pulse", 32'(cm_valid), 0);
    // reset while waiting in TX
    ex_valid = 1; ex_tx_req = 1; ex_tx_data = 8'h55;
    tick();
    clr();
    chk("rtx_valid", 32'(tx_valid), 1);
    #2 rst_n = 0;
    #1 chk("rtx_async_drop", 32'(tx_valid), 0);
    tx_ready = 1;
    tick();
    chk("rtx_no_cm", 32'(cm_valid), 0);
    rst_n = 1;
    tx_ready = 0;
    tick();
    chk("rtx_ready", 32'(ex_ready), 1);
    chk("rtx_no_cm2", 32'(cm_valid), 0);
    chk("rtx_no_tx", 32'(tx_valid), 0);
    tick();
    chk("rtx_no_cm3", 32'(cm_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_writeback.md
# cpu_writeback

Memory/writeback stage of the single-issue CPU. Consumes one executed-instruction record per handshake from the ALU stage and owns the 64×32 data RAM. Performs the load or store, the UART transmit request and the register-file write. Emits a one-cycle commit record (next PC plus interrupt state) back to the architectural state register feeding fetch/decode.

## Interface
Parameters:
- `DMEM_WORDS`, 64: data RAM depth. The address is `ex_mem_addr`, 6 bits.
- `RF_AW`, 4: register index width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ex_valid`  in  1  executed record valid.
- `ex_ready`  out  1  stage can accept a record.
- `ex_rd`  in  4  destination register index.
- `ex_pc`, `ex_intr_pc`, `ex_intr_vec`  in  32 each  next-PC and interrupt fields of the record.
- `ex_intr_en`, `ex_ack`  in  1 each  interrupt enable; interrupt acknowledge.
- `ex_w_rd`, `ex_mem_r_req`, `ex_mem_w_req`, `ex_tx_req`  in  1 each  request flags.
- `ex_x_rd`  in  32  ALU result, or store data.
- `ex_tx_data`  in  8  UART byte.
- `ex_mem_addr`  in  6  data RAM word address.
- `rf_we`  out  1  register write strobe.
- `rf_waddr`  out  4  register write index.
- `rf_wdata`  out  32  register write data.
- `tx_valid`  out  1  UART transmit request.
- `tx_data`  out  8  UART byte.
- `tx_ready`  in  1  UART accepts the byte this cycle.
- `cm_valid`  out  1  commit pulse.
- `cm_pc`, `cm_intr_pc`, `cm_intr_vec`  out  32 each  committed state.
- `cm_intr_en`  out  1  committed interrupt enable.
- `intr_ack`  out  1  interrupt controller acknowledge pulse.
- `stall_cnt`  out  32  stall counter. Present only with `CPU_WB_STALL_CNT_EN`.

## Operation
- FSM states:
  - `IDLE`: `ex_ready=1`.
  - `LOAD`: RAM read in flight.
  - `TX`: waiting for UART.
  - `COMMIT`: outputs driven for one cycle.
- Accept happens when `ex_valid && ex_ready`. All `ex_*` fields are captured into a holding register on that edge.
- Request priority is `mem_r_req` > `mem_w_req` > `tx_req`. A lower-priority flag set together with a higher one is ignored.
- Load:
  - RAM read is issued on the accept edge (synchronous RAM, 1-cycle read latency).
  - `IDLE→LOAD→COMMIT`. Write data is the RAM output, not `ex_x_rd`.
  - The register write happens only if `ex_w_rd`.
- Store: RAM is written with `ex_x_rd` at `ex_mem_addr` on the accept edge. `IDLE→COMMIT`. No register write.
- Transmit:
  - `IDLE→TX`. In `TX`, `tx_valid=1` and `tx_data` is held stable until `tx_ready=1`.
  - On that handshake edge the stage goes `TX→COMMIT`.
  - `tx_ready` sampled in `IDLE` is ignored.
- Plain record (no mem/tx flag): `IDLE→COMMIT`.
- `COMMIT` (exactly one cycle, then `IDLE`):
  - `cm_valid=1`, and all `cm_*` equal the captured fields.
  - `intr_ack=ex_ack` (captured).
  - `rf_we=w_rd && rd!=0`. Writes to register 0 are suppressed.
- `ex_ready=0` in `LOAD`, `TX` and `COMMIT`. At most one record is in flight.
- A store followed by a load to the same address returns the stored value, because the write completes before the next accept.

## Timing
- Reset values: every output is 0, state is `IDLE`, `stall_cnt=0`, and the holding register is 0. RAM contents are not reset and are undefined.
- Commit latency counts from the accept edge:
  - Plain and store: 1 cycle (`cm_valid` high in the cycle after accept).
  - Load: 2 cycles.
  - Tx: 1 cycle after the `tx_ready` handshake cycle.
- Throughput:
  - Plain and store: 1 record per 2 cycles.
  - Load: 1 per 3 cycles.
- `rf_we`, `cm_valid` and `intr_ack` are single-cycle pulses, all coincident in the `COMMIT` state.
- Reset mid-operation: an in-flight load or tx is abandoned, there is no commit, and `tx_valid` drops immediately (asynchronously). A RAM write already completed on an earlier edge persists.

## Configuration
- `CPU_WB_STALL_CNT_EN` defined:
  - `stall_cnt` exists. It increments by 1 in every cycle with `ex_valid && !ex_ready`, and every cycle in `TX` with `tx_ready=0`. A cycle meeting both conditions still adds only 1.
  - It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.
- Undefined: the port and the counter are absent. The rest of the behaviour is identical.

## Test plan
- Reset, then an `ex_valid` plain record with `w_rd=1`, `rd=3`, `x_rd=0x1234`, `pc=0x10`:
  - Next cycle: `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x1234`, `cm_valid=1`, `cm_pc=0x10`.
  - `ex_ready` low for exactly 1 cycle.
- Store `x_rd=0xDEADBEEF` to addr 63, then load addr 63 into rd 5:
  - Load commits 2 cycles after its accept with `rf_wdata=0xDEADBEEF`.
  - `ex_ready` is low for 2 cycles.
- Tx record `tx_data=0x41`, `tx_ready` held 0 for 5 cycles then 1:
  - `tx_valid=1`, `tx_data=0x41` held stable across all 6 cycles.
  - `cm_valid` asserts in the following cycle.
  - With the macro defined, `stall_cnt=5` plus any `ex_valid`-blocked cycles.
- Record with `w_rd=1`, `rd=0`, and a record with `mem_w_req=1` and `tx_req=1`:
  - `rd=0` record: no `rf_we`.
  - Combined record: RAM is written and `tx_valid` never asserts.
- Record with `ack=1`, `intr_en=1`, `intr_vec=0x80`: `intr_ack=1`, `cm_intr_en=1`, `cm_intr_vec=0x80` for exactly one cycle.
- Assert `rst_n=0` while in `TX`: `tx_valid` drops immediately, no `cm_valid` follows, and after release `ex_ready=1`.
